// File: rtl/vm1_bus_pkg.sv
// Shared definitions for the VM1-style bus cycle controller: state encoding,
// timeout default and write-lane helper.
package vm1_bus_pkg;

    localparam int TIMEOUT_DEFAULT = 64;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_DATA    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_ERR     = 3'd4
    } bus_state_e;

    // Byte writes replicate the low byte on both lanes; the slave picks the lane.
    function automatic logic [15:0] dout_lanes(input logic byte_acc, input logic [15:0] data);
        return byte_acc ? {data[7:0], data[7:0]} : data;
    endfunction

endpackage

// File: rtl/bus_timeout_cnt.sv
// Clock-enabled reply timer: clears on clr, counts on en, flags terminal count
// one cycle before the reply window closes.
module bus_timeout_cnt
    import vm1_bus_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ce) begin
            if (clr) begin
                cnt_d = '0;
            end else if (en) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/bus_cycle_ctl.sv
// Bus cycle sequencer between the datapath request port and a sync/reply style bus.
// state   | meaning
// IDLE    | waiting for req_rd/req_wr; latches address, data, width, direction
// ADDR    | address phase, bus_sync up, timer cleared
// DATA    | data strobe up, waiting for bus_rply or timeout
// RELEASE | strobes down, waiting for the slave to drop bus_rply
// ERR     | one-cycle buserr pulse (timeout or odd word address)
module bus_cycle_ctl
    import vm1_bus_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic        req_byte,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        done,
    output logic        buserr,
    output logic        busy,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_dout,
    input  logic [15:0] bus_din,
    output logic        bus_sync,
    output logic        bus_din_strobe,
    output logic        bus_dout_strobe,
    output logic        bus_byte,
    input  logic        bus_rply
);

    bus_state_e  state_q, state_d;
    logic        rd_q, rd_d;
    logic        byte_q, byte_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] dout_q, dout_d;
    logic [15:0] rdata_q, rdata_d;
    logic        sync_q, sync_d;
    logic        din_stb_q, din_stb_d;
    logic        dout_stb_q, dout_stb_d;
    logic        done_q, done_d;
    logic        buserr_q, buserr_d;
    logic        busy_q, busy_d;
    logic        tmr_tc;

    bus_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmr (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .clr   (state_q == ST_ADDR),
        .en    (state_q == ST_DATA),
        .tc    (tmr_tc)
    );

    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        byte_d     = byte_q;
        addr_d     = addr_q;
        dout_d     = dout_q;
        rdata_d    = rdata_q;
        sync_d     = sync_q;
        din_stb_d  = din_stb_q;
        dout_stb_d = dout_stb_q;
        done_d     = done_q;
        buserr_d   = buserr_q;
        busy_d     = busy_q;

        if (ce) begin
            done_d = 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (req_rd || req_wr) begin
                        addr_d  = addr;
                        dout_d  = dout_lanes(req_byte, wdata);
                        byte_d  = req_byte;
                        rd_d    = req_rd;
                        state_d = (!req_byte && addr[0]) ? ST_ERR : ST_ADDR;
                    end
                end
                ST_ADDR: state_d = ST_DATA;
                ST_DATA: begin
                    // A reply in the terminal-count cycle still completes the transfer.
                    if (bus_rply) begin
                        if (rd_q) begin
                            rdata_d = bus_din;
                        end
                        done_d  = 1'b1;
                        state_d = ST_RELEASE;
                    end else if (tmr_tc) begin
                        state_d = ST_ERR;
                    end
                end
                ST_RELEASE: begin
                    if (!bus_rply) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ERR:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase

            sync_d     = (state_d == ST_ADDR) || (state_d == ST_DATA);
            din_stb_d  = (state_d == ST_DATA) && rd_d;
            dout_stb_d = (state_d == ST_DATA) && !rd_d;
            buserr_d   = (state_d == ST_ERR);
            busy_d     = (state_d != ST_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rd_q       <= 1'b0;
            byte_q     <= 1'b0;
            addr_q     <= '0;
            dout_q     <= '0;
            rdata_q    <= '0;
            sync_q     <= 1'b0;
            din_stb_q  <= 1'b0;
            dout_stb_q <= 1'b0;
            done_q     <= 1'b0;
            buserr_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            byte_q     <= byte_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            rdata_q    <= rdata_d;
            sync_q     <= sync_d;
            din_stb_q  <= din_stb_d;
            dout_stb_q <= dout_stb_d;
            done_q     <= done_d;
            buserr_q   <= buserr_d;
            busy_q     <= busy_d;
        end
    end

    assign rdata           = rdata_q;
    assign done            = done_q;
    assign buserr          = buserr_q;
    assign busy            = busy_q;
    assign bus_addr        = addr_q;
    assign bus_dout        = dout_q;
    assign bus_sync        = sync_q;
    assign bus_din_strobe  = din_stb_q;
    assign bus_dout_strobe = dout_stb_q;
    assign bus_byte        = byte_q;

endmodule
